// File: rtl/cfa_pkg.sv
// ============================================================================
// Module      : cfa_pkg
// Description : Shared Bayer CFA symbol/pattern constants and symbol lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfa_pkg;

    localparam logic [1:0] SYM_GREEN = 2'b01;
    localparam logic [1:0] SYM_RED   = 2'b10;
    localparam logic [1:0] SYM_BLUE  = 2'b11;

    localparam logic [1:0] PAT_RGGB  = 2'b00;
    localparam logic [1:0] PAT_GRBG  = 2'b01;
    localparam logic [1:0] PAT_GBRG  = 2'b10;
    localparam logic [1:0] PAT_BGGR  = 2'b11;

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_ACTIVE   = 1'b1
    } cfa_state_t;

    // Green always sits on one diagonal of the 2x2 cell; red/blue fill the other.
    function automatic logic [1:0] cfa_symbol(
        input logic [1:0] pattern,
        input logic       row_par,
        input logic       col_par
    );
        logic [1:0] idx;
        idx        = {row_par, col_par};
        cfa_symbol = SYM_GREEN;
        case (pattern)
            PAT_RGGB: begin
                if (idx == 2'b00) cfa_symbol = SYM_RED;
                if (idx == 2'b11) cfa_symbol = SYM_BLUE;
            end
            PAT_GRBG: begin
                if (idx == 2'b01) cfa_symbol = SYM_RED;
                if (idx == 2'b10) cfa_symbol = SYM_BLUE;
            end
            PAT_GBRG: begin
                if (idx == 2'b01) cfa_symbol = SYM_BLUE;
                if (idx == 2'b10) cfa_symbol = SYM_RED;
            end
            default: begin
                if (idx == 2'b00) cfa_symbol = SYM_BLUE;
                if (idx == 2'b11) cfa_symbol = SYM_RED;
            end
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfa_raster_counter.sv
// ============================================================================
// Module      : cfa_raster_counter
// Description : Column/row raster position with wrap, eol/eof flags and restart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfa_raster_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = $clog2(WIDTH),
    parameter int RW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic          restart,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          eol,
    output logic          eof
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // The registers hold the position of the next beat; restart overrides it.
    always_comb begin
        col   = restart ? '0 : col_q;
        row   = restart ? '0 : row_q;
        eol   = (col == CW'(WIDTH - 1));
        eof   = eol && (row == RW'(HEIGHT - 1));
        col_d = col_q;
        row_d = row_q;
        if (adv) begin
            if (eof) begin
                col_d = '0;
                row_d = '0;
            end else if (eol) begin
                col_d = '0;
                row_d = row + RW'(1);
            end else begin
                col_d = col + CW'(1);
                row_d = row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cfa_mosaic.sv
// ============================================================================
// Module      : cfa_mosaic
// Description : RGB pixel stream to Bayer raw stream with CFA symbol tags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfa_mosaic
    import cfa_pkg::*;
#(
    parameter int DW     = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pattern_sel,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_sof,
    input  logic [DW-1:0] s_r,
    input  logic [DW-1:0] s_g,
    input  logic [DW-1:0] s_b,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    m_symbol,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof,
    output logic          frame_start,
    output logic          row_update,
    output logic          col_update,
    output logic          err_sof
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    cfa_state_t    state_q, state_d;
    logic [1:0]    pattern_q, pattern_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [1:0]    m_symbol_q, m_symbol_d;
    logic          m_sof_q, m_sof_d;
    logic          m_eol_q, m_eol_d;
    logic          m_eof_q, m_eof_d;

    logic          accept;
    logic          emit;
    logic          xfer;
    logic [1:0]    pattern_eff;
    logic [1:0]    sym;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          cur_eol;
    logic          cur_eof;

    cfa_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .CW     (CW),
        .RW     (RW)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .adv     (emit),
        .restart (s_sof),
        .col     (cur_col),
        .row     (cur_row),
        .eol     (cur_eol),
        .eof     (cur_eof)
    );

    always_comb begin
        s_ready     = ~m_valid_q | m_ready;
        accept      = s_valid & s_ready;
        // Non-SOF beats while waiting for a frame are swallowed without output.
        emit        = accept & ((state_q == ST_ACTIVE) | s_sof);
        xfer        = m_valid_q & m_ready;
        pattern_eff = s_sof ? pattern_sel : pattern_q;
        sym         = cfa_symbol(pattern_eff, cur_row[0], cur_col[0]);

        frame_start = ~rst & accept & s_sof;
        err_sof     = ~rst & accept & ((state_q == ST_ACTIVE) ? s_sof : ~s_sof);
        row_update  = ~rst & xfer & m_eol_q & ~m_eof_q;
        col_update  = ~rst & xfer & ~m_eol_q & ~m_eof_q;

        state_d     = state_q;
        pattern_d   = (accept & s_sof) ? pattern_sel : pattern_q;
        m_valid_d   = m_valid_q & ~m_ready;
        m_data_d    = m_data_q;
        m_symbol_d  = m_symbol_q;
        m_sof_d     = m_sof_q;
        m_eol_d     = m_eol_q;
        m_eof_d     = m_eof_q;

        if (emit) begin
            state_d    = cur_eof ? ST_WAIT_SOF : ST_ACTIVE;
            m_valid_d  = 1'b1;
            m_symbol_d = sym;
            m_sof_d    = (cur_col == '0) && (cur_row == '0);
            m_eol_d    = cur_eol;
            m_eof_d    = cur_eof;
            case (sym)
                SYM_RED:  m_data_d = s_r;
                SYM_BLUE: m_data_d = s_b;
                default:  m_data_d = s_g;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT_SOF;
            pattern_q  <= PAT_RGGB;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_symbol_q <= 2'b00;
            m_sof_q    <= 1'b0;
            m_eol_q    <= 1'b0;
            m_eof_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_symbol_q <= m_symbol_d;
            m_sof_q    <= m_sof_d;
            m_eol_q    <= m_eol_d;
            m_eof_q    <= m_eof_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_symbol = m_symbol_q;
    assign m_sof    = m_sof_q;
    assign m_eol    = m_eol_q;
    assign m_eof    = m_eof_q;

endmodule

`default_nettype wire

// File: tb/tb_cfa_mosaic.sv
// ============================================================================
// Module      : tb_cfa_mosaic
// Description : Self-checking bench for cfa_mosaic on a 4x2 frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfa_mosaic;

    localparam int W = 4;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pattern_sel = 2'b00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       s_sof = 1'b0;
    logic [7:0] s_r = 8'h0, s_g = 8'h0, s_b = 8'h0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic [1:0] m_symbol;
    logic       m_sof, m_eol, m_eof;
    logic       frame_start, row_update, col_update, err_sof;

    cfa_mosaic #(.DW(8), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .pattern_sel(pattern_sel),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_r(s_r), .s_g(s_g), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_symbol(m_symbol),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .frame_start(frame_start), .row_update(row_update),
        .col_update(col_update), .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;

    // Reference: expected output register contents and frame position.
    bit         mv;
    logic [7:0] mdata;
    logic [1:0] msym;
    bit         msof, meol, meof;
    bit         active;
    int         k;
    logic [1:0] pat;

    logic [7:0] xq[$];
    int         n_col, n_row;
    string      pat_names[4] = '{"RGGB", "GRBG", "GBRG", "BGGR"};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv = 0; mdata = 0; msym = 0; msof = 0; meol = 0; meof = 0;
        active = 0; k = 0; pat = 0;
    endtask

    task automatic cycle(input bit v, input bit sof, input logic [1:0] ps,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input bit rs, output bit acc);
        bit rdy, e_ready, xfer, emit;
        int row, col;
        string nm;
        byte ch;
        @(negedge clk);
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        cyc++;
        rst = rs; s_valid = v; s_sof = sof; pattern_sel = ps;
        s_r = r; s_g = g; s_b = b; m_ready = rdy;
        #1;
        e_ready = !mv || rdy;
        acc     = v && e_ready;
        xfer    = mv && rdy;
        check("s_ready", 32'(s_ready), 32'(e_ready));
        check("m_valid", 32'(m_valid), 32'(mv));
        check("m_data", 32'(m_data), 32'(mdata));
        check("m_symbol", 32'(m_symbol), 32'(msym));
        check("m_sof", 32'(m_sof), 32'(msof));
        check("m_eol", 32'(m_eol), 32'(meol));
        check("m_eof", 32'(m_eof), 32'(meof));
        check("frame_start", 32'(frame_start), 32'(!rs && acc && sof));
        check("err_sof", 32'(err_sof), 32'(!rs && acc && (active ? sof : !sof)));
        check("row_update", 32'(row_update), 32'(!rs && xfer && meol && !meof));
        check("col_update", 32'(col_update), 32'(!rs && xfer && !meol && !meof));
        if (!rs && xfer) xq.push_back(m_data);
        if (col_update === 1'b1) n_col++;
        if (row_update === 1'b1) n_row++;
        emit = acc && (active || sof);
        if (rs) begin
            model_reset();
        end else if (emit) begin
            if (sof) begin pat = ps; k = 0; end
            row = k / W;
            col = k % W;
            nm  = pat_names[pat];
            ch  = nm[(row % 2) * 2 + (col % 2)];
            if (ch == "R") begin msym = 2'b10; mdata = r; end
            else if (ch == "B") begin msym = 2'b11; mdata = b; end
            else begin msym = 2'b01; mdata = g; end
            msof = (k == 0);
            meol = (col == W - 1);
            meof = (k == W * H - 1);
            mv = 1;
            k++;
            active = !meof;
        end else if (rdy) begin
            mv = 0;
        end
    endtask

    task automatic send_beat(input bit sof, input logic [1:0] ps,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc && tries < 50) begin
            cycle(1'b1, sof, ps, r, g, b, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout observed=0 required=1");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 8'h0, 8'h0, 8'h0, 1'b0, acc);
    endtask

    task automatic rand_frame(input logic [1:0] ps);
        for (int i = 0; i < W * H; i++)
            send_beat(i == 0, ps, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    logic [7:0] exp_first[8] = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h22, 8'h33, 8'h22, 8'h33};

    initial begin
        bit acc;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        model_reset();
        cycle(1'b0, 1'b0, 2'b00, 8'h0, 8'h0, 8'h0, 1'b1, acc);

        // Reset state
        #1;
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_m_symbol", 32'(m_symbol), 32'd0);

        // Directed RGGB frame with fixed channel values
        xq.delete(); n_col = 0; n_row = 0;
        for (int i = 0; i < W * H; i++) send_beat(i == 0, 2'b00, 8'h11, 8'h22, 8'h33);
        idle(2);
        check("first_frame_len", 32'(xq.size()), 32'd8);
        for (int i = 0; i < 8 && i < xq.size(); i++)
            check($sformatf("first_frame_data%0d", i), 32'(xq[i]), 32'(exp_first[i]));
        check("first_frame_col_updates", 32'(n_col), 32'd6);
        check("first_frame_row_updates", 32'(n_row), 32'd1);

        // Remaining patterns, random pixel data
        for (int p = 1; p < 4; p++) begin
            rand_frame(2'(p));
            idle(1);
        end

        // Output stall pattern 1,0,0,1
        rdy_mode = 1;
        rand_frame(2'(3));
        rand_frame(2'(1));
        idle(4);
        rdy_mode = 0;

        // Non-SOF beats after reset are dropped with err_sof
        cycle(1'b0, 1'b0, 2'b00, 8'h0, 8'h0, 8'h0, 1'b1, acc);
        for (int i = 0; i < 3; i++) send_beat(1'b0, 2'b00, 8'($urandom), 8'($urandom), 8'($urandom));
        rand_frame(2'(2));
        idle(1);

        // SOF on the 6th pixel restarts with the new pattern
        for (int i = 0; i < 5; i++) send_beat(i == 0, 2'b00, 8'($urandom), 8'($urandom), 8'($urandom));
        send_beat(1'b1, 2'b11, 8'h5a, 8'h6b, 8'h7c);
        @(posedge clk);
        #1;
        check("midsof_m_sof", 32'(m_sof), 32'd1);
        check("midsof_symbol", 32'(m_symbol), 32'd3);
        check("midsof_data", 32'(m_data), 32'h7c);
        for (int i = 1; i < W * H; i++) send_beat(1'b0, 2'b11, 8'($urandom), 8'($urandom), 8'($urandom));
        idle(1);

        // Reset while output is valid mid-frame
        for (int i = 0; i < 3; i++) send_beat(i == 0, 2'b01, 8'($urandom), 8'($urandom), 8'($urandom));
        cycle(1'b0, 1'b0, 2'b00, 8'h0, 8'h0, 8'h0, 1'b1, acc);
        send_beat(1'b0, 2'b00, 8'h01, 8'h02, 8'h03);
        rand_frame(2'(0));

        // Random soak
        rdy_mode = 2;
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                  2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, acc);
        rdy_mode = 0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
